// File: rtl/layer_buf_slave_pkg.sv
// Shared constants for the layer buffer slave and the layer reader/writer masters.
package layer_buf_slave_pkg;

  localparam int unsigned LB_DEPTH     = 1024;
  localparam logic [31:0] LB_BASE_ADDR = 32'd400_000;
  localparam int unsigned LB_DATA_W    = 16;
  localparam logic [15:0] LB_ERR_WORD  = 16'hDEAD;

  typedef logic [LB_DATA_W-1:0] lb_word_t;

  typedef enum logic [1:0] {
    LB_IDLE,
    LB_RD,
    LB_WR,
    LB_ILLEGAL
  } lb_req_e;

  function automatic lb_req_e lb_classify(input logic cs, input logic rd_n, input logic wr_n);
    if (!cs)               return LB_IDLE;
    else if (!rd_n && wr_n) return LB_RD;
    else if (rd_n && !wr_n) return LB_WR;
    else if (!rd_n && !wr_n) return LB_ILLEGAL;
    else                    return LB_IDLE;
  endfunction

endpackage

// File: rtl/avs_rd_pipe.sv
// Read response pipeline: valid shifts LATENCY stages; data follows one stage
// behind because it comes out of the registered RAM read port.
module avs_rd_pipe #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned WIDTH   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             acc_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic [LATENCY-1:0] vld_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= acc_i;
      for (int unsigned k = 1; k < LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
    end
  end

  assign valid_o = vld_q[LATENCY-1];

  if (LATENCY == 1) begin : g_direct
    assign data_o = data_i;
  end else begin : g_stages
    // dat_q[j] travels with vld_q[j+1]; stages load only when a response
    // enters, so the last stage holds the previous response when idle.
    logic [WIDTH-1:0] dat_q [LATENCY-1];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int unsigned j = 0; j < LATENCY - 1; j++) begin
          dat_q[j] <= '0;
        end
      end else begin
        if (vld_q[0]) dat_q[0] <= data_i;
        for (int unsigned j = 1; j < LATENCY - 1; j++) begin
          if (vld_q[j]) dat_q[j] <= dat_q[j-1];
        end
      end
    end

    assign data_o = dat_q[LATENCY-2];
  end

endmodule

// File: rtl/layer_buf_slave.sv
// Avalon-MM slave holding a 16-bit layer buffer with pipelined, in-order
// read responses and byte-enabled writes.
module layer_buf_slave
  import layer_buf_slave_pkg::*;
#(
  parameter int unsigned DEPTH     = LB_DEPTH,
  parameter logic [31:0] BASE_ADDR = LB_BASE_ADDR,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned MAX_PEND  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] address,
  input  logic [1:0]  byteenable,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        readdatavalid,
  output logic        waitrequest,
  output logic [31:0] toHexLed
);

  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PEND_W = $clog2(MAX_PEND + 1);

  lb_req_e           req;
  logic [31:0]       offset;
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              rd_acc, wr_acc, err_inc;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [11:0]       rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  lb_word_t          mem_q [DEPTH];
  lb_word_t          ram_rd_q, rd_word;
  logic              oor_q, rd_zero_q;

  assign offset   = address - BASE_ADDR;
  assign idx      = offset[IDX_W:1];
  assign in_range = (address >= BASE_ADDR) && !address[0] && ((offset >> 1) < 32'(DEPTH));

  always_comb begin
    req         = lb_classify(chipselect, read_n, write_n);
    waitrequest = 1'b0;
    if (!reset) begin
      if (req == LB_RD)      waitrequest = (pend_q == PEND_W'(MAX_PEND));
      else if (req == LB_WR) waitrequest = (pend_q != '0);
    end
    rd_acc  = !reset && (req == LB_RD) && !waitrequest;
    wr_acc  = !reset && (req == LB_WR) && !waitrequest;
    err_inc = ((rd_acc || wr_acc) && !in_range) || (!reset && (req == LB_ILLEGAL));
  end

  always_comb begin
    pend_d = pend_q;
    case ({rd_acc, readdatavalid})
      2'b10:   pend_d = pend_q + 1'b1;
      2'b01:   pend_d = pend_q - 1'b1;
      default: pend_d = pend_q;
    endcase
    rd_cnt_d  = (rd_acc  && rd_cnt_q  != '1) ? rd_cnt_q  + 1'b1 : rd_cnt_q;
    wr_cnt_d  = (wr_acc  && wr_cnt_q  != '1) ? wr_cnt_q  + 1'b1 : wr_cnt_q;
    err_cnt_d = (err_inc && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q    <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
      oor_q     <= 1'b0;
      rd_zero_q <= 1'b1;
    end else begin
      pend_q    <= pend_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
      if (rd_acc) begin
        oor_q     <= !in_range;
        rd_zero_q <= 1'b0;
      end
    end
  end

  // Reads and writes are mutually exclusive by request decode: one RAM port.
  always_ff @(posedge clk) begin
    if (wr_acc && in_range) begin
      if (byteenable[0]) mem_q[idx][7:0]  <= writedata[7:0];
      if (byteenable[1]) mem_q[idx][15:8] <= writedata[15:8];
    end
    if (rd_acc && in_range) ram_rd_q <= mem_q[idx];
  end

  assign rd_word = rd_zero_q ? '0 : (oor_q ? LB_ERR_WORD : ram_rd_q);

  avs_rd_pipe #(
    .LATENCY(LATENCY),
    .WIDTH  (LB_DATA_W)
  ) u_rd_pipe (
    .clk    (clk),
    .reset  (reset),
    .acc_i  (rd_acc),
    .data_i (rd_word),
    .valid_o(readdatavalid),
    .data_o (readdata)
  );

  assign toHexLed = {rd_cnt_q, wr_cnt_q, err_cnt_q};

endmodule

// File: tb/tb_layer_buf_slave.sv
// Directed bench for layer_buf_slave: default instance plus a LATENCY=4 instance.
module tb_layer_buf_slave;

  typedef enum logic [1:0] {OP_W, OP_R, OP_BOTH} op_e;

  typedef struct {
    op_e         op;
    logic [31:0] addr;
    logic [1:0]  be;
    logic [15:0] wd;
    logic [15:0] exp_data;
    logic [11:0] exp_rd;
    logic [11:0] exp_wr;
    logic [7:0]  exp_err;
  } vec_t;

  localparam int NV = 17;
  localparam logic [31:0] BASE = 32'd400_000;

  logic        clk, rst;
  logic        cs, rd_n, wr_n;
  logic [31:0] addr;
  logic [1:0]  be;
  logic [15:0] wd, rdata;
  logic        rvalid, wreq;
  logic [31:0] led;

  logic        cs4, rd_n4, wr_n4;
  logic [31:0] addr4;
  logic [1:0]  be4;
  logic [15:0] wd4, rdata4;
  logic        rvalid4, wreq4;
  logic [31:0] led4;

  int n_chk  = 0;
  int n_pass = 0;

  vec_t vecs [NV];
  logic [15:0] vq  [$];
  logic [15:0] vq4 [$];

  layer_buf_slave dut (
    .clk(clk), .reset(rst), .chipselect(cs), .read_n(rd_n), .write_n(wr_n),
    .address(addr), .byteenable(be), .writedata(wd), .readdata(rdata),
    .readdatavalid(rvalid), .waitrequest(wreq), .toHexLed(led)
  );

  layer_buf_slave #(.LATENCY(4), .MAX_PEND(4)) dut4 (
    .clk(clk), .reset(rst), .chipselect(cs4), .read_n(rd_n4), .write_n(wr_n4),
    .address(addr4), .byteenable(be4), .writedata(wd4), .readdata(rdata4),
    .readdatavalid(rvalid4), .waitrequest(wreq4), .toHexLed(led4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rvalid)  vq.push_back(rdata);
    if (rvalid4) vq4.push_back(rdata4);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    cs = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic wr_do(input logic [31:0] a, input logic [1:0] b, input logic [15:0] d, input string nm);
    cs = 1'b1; rd_n = 1'b1; wr_n = 1'b0; addr = a; be = b; wd = d;
    #1; check({nm, "_wait"}, 32'(wreq), 32'd0);
    step();
    idle();
  endtask

  task automatic rd_check(input logic [31:0] a, input logic [15:0] exp, input string nm);
    cs = 1'b1; rd_n = 1'b0; wr_n = 1'b1; addr = a;
    #1; check({nm, "_wait"}, 32'(wreq), 32'd0);
    step();
    idle();
    check({nm, "_early"}, 32'(rvalid), 32'd0);
    step();
    check({nm, "_vld"}, 32'(rvalid), 32'd1);
    check({nm, "_data"}, 32'(rdata), 32'(exp));
    step();
  endtask

  initial begin
    logic [6:0] exp_w4;
    int n4;
    logic acc4;

    vecs[0]  = '{OP_W,    BASE,          2'b11, 16'h1234, 16'h0000, 12'd0, 12'd1, 8'd0};
    vecs[1]  = '{OP_R,    BASE,          2'b11, 16'h0000, 16'h1234, 12'd1, 12'd1, 8'd0};
    vecs[2]  = '{OP_W,    32'd400002,    2'b11, 16'hABCD, 16'h0000, 12'd1, 12'd2, 8'd0};
    vecs[3]  = '{OP_W,    32'd400002,    2'b01, 16'h0055, 16'h0000, 12'd1, 12'd3, 8'd0};
    vecs[4]  = '{OP_R,    32'd400002,    2'b11, 16'h0000, 16'hAB55, 12'd2, 12'd3, 8'd0};
    vecs[5]  = '{OP_W,    32'd402046,    2'b11, 16'hBEEF, 16'h0000, 12'd2, 12'd4, 8'd0};
    vecs[6]  = '{OP_R,    32'd402046,    2'b11, 16'h0000, 16'hBEEF, 12'd3, 12'd4, 8'd0};
    vecs[7]  = '{OP_W,    32'd402048,    2'b11, 16'hFFFF, 16'h0000, 12'd3, 12'd5, 8'd1};
    vecs[8]  = '{OP_R,    BASE,          2'b11, 16'h0000, 16'h1234, 12'd4, 12'd5, 8'd1};
    vecs[9]  = '{OP_R,    32'd399998,    2'b11, 16'h0000, 16'hDEAD, 12'd5, 12'd5, 8'd2};
    vecs[10] = '{OP_R,    32'd400001,    2'b11, 16'h0000, 16'hDEAD, 12'd6, 12'd5, 8'd3};
    vecs[11] = '{OP_BOTH, BASE,          2'b11, 16'h0000, 16'h0000, 12'd6, 12'd5, 8'd4};
    vecs[12] = '{OP_R,    BASE,          2'b11, 16'h0000, 16'h1234, 12'd7, 12'd5, 8'd4};
    vecs[13] = '{OP_R,    32'd402048,    2'b11, 16'h0000, 16'hDEAD, 12'd8, 12'd5, 8'd5};
    vecs[14] = '{OP_W,    32'd400004,    2'b11, 16'h1111, 16'h0000, 12'd8, 12'd6, 8'd5};
    vecs[15] = '{OP_W,    32'd400004,    2'b10, 16'hA5C3, 16'h0000, 12'd8, 12'd7, 8'd5};
    vecs[16] = '{OP_R,    32'd400004,    2'b11, 16'h0000, 16'hA511, 12'd9, 12'd7, 8'd5};

    rst = 1'b1;
    idle(); addr = BASE; be = 2'b11; wd = '0;
    cs4 = 1'b0; rd_n4 = 1'b1; wr_n4 = 1'b1; addr4 = BASE; be4 = 2'b11; wd4 = '0;
    repeat (3) step();
    rst = 1'b0;
    #1;
    check("rst_led", led, 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_wait", 32'(wreq), 32'd0);

    for (int i = 0; i < NV; i++) begin
      string nm;
      nm = $sformatf("v%0d", i);
      case (vecs[i].op)
        OP_W: wr_do(vecs[i].addr, vecs[i].be, vecs[i].wd, nm);
        OP_R: rd_check(vecs[i].addr, vecs[i].exp_data, nm);
        default: begin
          cs = 1'b1; rd_n = 1'b0; wr_n = 1'b0; addr = vecs[i].addr; be = vecs[i].be; wd = vecs[i].wd;
          #1; check({nm, "_wait"}, 32'(wreq), 32'd0);
          step();
          idle();
          check({nm, "_novld"}, 32'(rvalid), 32'd0);
        end
      endcase
      check({nm, "_led"}, led, {vecs[i].exp_rd, vecs[i].exp_wr, vecs[i].exp_err});
    end

    // write held off behind two in-flight reads
    vq.delete();
    cs = 1'b1; rd_n = 1'b0; wr_n = 1'b1; addr = BASE;
    step();
    addr = 32'd400002;
    step();
    rd_n = 1'b1; wr_n = 1'b0; addr = 32'd400008; be = 2'b11; wd = 16'h7777;
    #1; check("wr_stall1", 32'(wreq), 32'd1);
    step();
    check("wr_stall2", 32'(wreq), 32'd1);
    step();
    check("wr_go", 32'(wreq), 32'd0);
    step();
    idle();
    check("ord_cnt", 32'(vq.size()), 32'd2);
    if (vq.size() == 2) begin
      check("ord_0", 32'(vq[0]), 32'h1234);
      check("ord_1", 32'(vq[1]), 32'hAB55);
    end
    rd_check(32'd400008, 16'h7777, "wr_after");

    // MAX_PEND stall on the LATENCY=4 instance
    for (int i = 0; i < 6; i++) begin
      cs4 = 1'b1; rd_n4 = 1'b1; wr_n4 = 1'b0; addr4 = BASE + 32'(2 * i); be4 = 2'b11;
      wd4 = 16'hC000 + 16'(i);
      step();
    end
    cs4 = 1'b0; wr_n4 = 1'b1;
    vq4.delete();
    exp_w4 = 7'b0010000;
    n4 = 0;
    for (int c = 0; c < 12; c++) begin
      if (n4 < 6) begin
        cs4 = 1'b1; rd_n4 = 1'b0; wr_n4 = 1'b1; addr4 = BASE + 32'(2 * n4);
      end else begin
        cs4 = 1'b0; rd_n4 = 1'b1; wr_n4 = 1'b1;
      end
      #1;
      if (c < 7) check($sformatf("stall_w%0d", c), 32'(wreq4), 32'(exp_w4[c]));
      acc4 = (n4 < 6) && !wreq4;
      step();
      if (acc4) n4++;
    end
    check("stall_issued", 32'(n4), 32'd6);
    check("stall_vcnt", 32'(vq4.size()), 32'd6);
    for (int i = 0; i < 6 && i < vq4.size(); i++) begin
      check($sformatf("stall_d%0d", i), 32'(vq4[i]), 32'(16'hC000 + 16'(i)));
    end
    check("stall_led", led4, {12'd6, 12'd6, 8'd0});

    // reset one cycle after three reads accepted, write request held through reset
    cs = 1'b1; rd_n = 1'b0; wr_n = 1'b1; addr = BASE;
    step();
    addr = 32'd400002;
    step();
    addr = 32'd400004;
    step();
    vq.delete();
    rst = 1'b1; rd_n = 1'b1; wr_n = 1'b0; addr = BASE; be = 2'b11; wd = 16'hFFFF;
    #1; check("rstw_wait0", 32'(wreq), 32'd0);
    step();
    check("rstw_wait1", 32'(wreq), 32'd0);
    step();
    rst = 1'b0;
    idle();
    repeat (6) step();
    check("rst_novld", 32'(vq.size()), 32'd0);
    check("rst2_led", led, 32'd0);
    check("rst2_rdata", 32'(rdata), 32'd0);

    rd_check(32'd399998, 16'hDEAD, "oor_lo");
    rd_check(32'd400001, 16'hDEAD, "oor_odd");
    check("oor_led", led, {12'd2, 12'd0, 8'd2});
    rd_check(BASE, 16'h1234, "mem_kept");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
